ahb_ext_responder: RTL and testbench
====================================

# ahb_ext_responder

Parametrised AHB-Lite subordinate that answers the SoC's external-bus select (HSELEXT) in simulation and lint wrappers, replacing the fixed tie-offs of always-ready, always-OKAY, zero read data. It provides a byte-writable word memory and a programmable wait-state count per transfer. An optional error window returns the two-cycle ERROR response. The testbench can then exercise the external-bus path of the core, including stalls and bus faults.

## Interface
- AHBW, 64: data bus width in bits; 32 or 64.
- PA_BITS, 34: physical address width.
- DEPTH, 4096: memory depth in AHBW-wide words; power of two.
- ERR_BASE, 0: base of the error window (byte address).
- ERR_MASK, 0: address bits ignored when matching ERR_BASE; ERR_MASK=0 with ERR_EN=0 disables errors.
- ERR_EN, 0: 1 enables the error window.
- SEQ_WAIT, 1: 1 = SEQ beats take WaitCycles; 0 = only NONSEQ beats wait, SEQ beats complete zero-wait.
- HCLK  in  1  bus clock.
- HRESETn  in  1  asynchronous, active-low reset.
- HSELEXT  in  1  subordinate select.
- HADDR  in  PA_BITS  transfer address.
- HTRANS  in  2  IDLE/BUSY/NONSEQ/SEQ.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  transfer size (informational; HWSTRB governs byte writes).
- HWDATA  in  AHBW  write data, valid in data phase.
- HWSTRB  in  AHBW/8  byte write strobes, valid in data phase.
- HREADY  in  1  bus-level ready (address phase accepted when high).
- WaitCycles  in  4  wait states to insert, sampled at each accepted address phase.
- HRDATAEXT  out  AHBW  read data.
- HREADYEXT  out  1  subordinate ready.
- HRESPEXT  out  1  0 = OKAY, 1 = ERROR.

## Operation
- Accept: address phase accepted on a rising HCLK edge with HSELEXT & HTRANS[1] & HREADY. Capture the index HADDR[log2(AHBW/8) +: log2(DEPTH)], HWRITE, HTRANS, and error-window match ((HADDR & ~ERR_MASK) == (ERR_BASE & ~ERR_MASK)) & ERR_EN.
- Higher address bits are ignored: addresses alias modulo DEPTH words.
- Wait load: the wait count is WaitCycles, forced to 0 when SEQ_WAIT=0 and HTRANS=SEQ.
- IDLE/BUSY while selected with HREADY high: no data phase state, OKAY zero-wait response.
- States: IDLE, DATA, ERR.
  - IDLE to DATA on an accept with no error match.
  - IDLE to ERR on an accept with an error match.
  - DATA with count>0: HREADYEXT=0, count decrements.
  - DATA with count=0: completion cycle, HREADYEXT=1, HRESPEXT=0. The next state is DATA or ERR if a new accept happens on the same edge (back-to-back), else IDLE.
  - ERR cycle 1: HREADYEXT=0, HRESPEXT=1. ERR cycle 2: HREADYEXT=1, HRESPEXT=1, then IDLE or a new accept.
- Error transfers take no wait states and never modify memory.
- Write: at the completion-cycle edge, memory bytes with HWSTRB[i]=1 take HWDATA[8i+7:8i]; other bytes are unchanged.
- Read: HRDATAEXT = mem[index] during the completion cycle, and 0 in all other cycles.
- Memory is not initialised by reset (X in simulation). A testbench may preload it hierarchically.

## Timing
- Reset values: HREADYEXT=1, HRESPEXT=0, HRDATAEXT=0, state IDLE, count 0.
- Reset asserted mid-transfer aborts the transfer immediately, with no memory write. Outputs take their reset values asynchronously.
- Latency: a zero-wait transfer completes in the cycle after its address phase. Each wait state adds one cycle. An ERROR response always takes 2 cycles.
- Read-after-write to the same word, back-to-back: the write commits at the edge ending its data phase, so the following read returns the new data with no forwarding stall.
- Simultaneous completion and new accept: supported every cycle, giving a fully pipelined stream at zero wait.
- WaitCycles changes during a data phase have no effect on the transfer in flight.
- HSELEXT deasserted: no new transfer starts; a data phase in flight still completes.

## Test plan
- Reset: hold HRESETn=0 for 3 cycles, then release → HREADYEXT=1, HRESPEXT=0, HRDATAEXT=0 for all cycles with HSELEXT=0.
- Zero-wait write/read:
  - Stimulus: write 0x1122334455667788 to 0x100 with all strobes, then a back-to-back read of 0x100.
  - Response: the read completes 1 cycle after its address phase, with HRDATAEXT=0x1122334455667788.
- Byte strobes: write 0xFFFF_FFFF_FFFF_FFFF to 0x100 with HWSTRB=0x0F, then read → 0x11223344FFFFFFFF.
- Wait states:
  - Stimulus: WaitCycles=3, read 0x100.
  - Response: HREADYEXT low for exactly 3 cycles, then high with data.
  - Stimulus: WaitCycles=3, SEQ_WAIT=0, a 4-beat INCR burst.
  - Response: only the NONSEQ beat waits 3 cycles.
- Error window:
  - Stimulus: ERR_EN=1, ERR_BASE=0x2000, ERR_MASK=0xFFF, write to 0x2010.
  - Response: HRESPEXT=1 for 2 cycles, with HREADYEXT 0 then 1.
  - Stimulus: read 0x2010 afterwards.
  - Response: ERROR again; the aliasing word is unchanged.
- Reset mid-wait: WaitCycles=5 write to 0x200, assert HRESETn at wait cycle 2, release, then read 0x200 → previous contents are returned, not the new write data.

Source files
------------

// File: rtl/ahb_ext_responder_if.sv
// AHB-Lite bus bundle for the external-bus responder.
// The master modport is the requesting side; the slave modport is the responder.
interface ahb_ext_responder_if #(
  parameter int AHBW    = 64,
  parameter int PA_BITS = 34
);
  logic                HSELEXT;
  logic [PA_BITS-1:0]  HADDR;
  logic [1:0]          HTRANS;
  logic                HWRITE;
  logic [2:0]          HSIZE;
  logic [AHBW-1:0]     HWDATA;
  logic [AHBW/8-1:0]   HWSTRB;
  logic                HREADY;
  logic [AHBW-1:0]     HRDATAEXT;
  logic                HREADYEXT;
  logic                HRESPEXT;

  modport master (
    output HSELEXT, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HWSTRB, HREADY,
    input  HRDATAEXT, HREADYEXT, HRESPEXT
  );

  modport slave (
    input  HSELEXT, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HWSTRB, HREADY,
    output HRDATAEXT, HREADYEXT, HRESPEXT
  );
endinterface

// File: rtl/ahb_ext_responder.sv
// AHB-Lite external-bus responder: byte-writable word memory, programmable
// wait states per transfer, optional address window answering with ERROR.
module ahb_ext_responder #(
  parameter int                 AHBW     = 64,
  parameter int                 PA_BITS  = 34,
  parameter int                 DEPTH    = 4096,
  parameter logic [PA_BITS-1:0] ERR_BASE = '0,
  parameter logic [PA_BITS-1:0] ERR_MASK = '0,
  parameter bit                 ERR_EN   = 1'b0,
  parameter bit                 SEQ_WAIT = 1'b1
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic [3:0]        WaitCycles,
  ahb_ext_responder_if.slave bus
);
  localparam int NB = AHBW / 8;
  localparam int BO = $clog2(NB);
  localparam int IW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_ERR1 = 2'd2;
  localparam logic [1:0] S_ERR2 = 2'd3;
  localparam logic [1:0] TR_SEQ = 2'b11;

  // data-phase context captured at the accepted address phase
  typedef struct packed {
    logic [IW-1:0] idx;
    logic          wr;
  } dph_t;

  logic [1:0]      state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  dph_t            dph_q, dph_d;
  logic [AHBW-1:0] mem_q [DEPTH];

  logic accept, err_hit, done, mem_we;

  // address-phase qualification and completion decode
  always_comb begin
    accept  = bus.HSELEXT & bus.HTRANS[1] & bus.HREADY;
    err_hit = ERR_EN && ((bus.HADDR & ~ERR_MASK) == (ERR_BASE & ~ERR_MASK));
    done    = (state_q == S_DATA) && (cnt_q == 4'd0);
    mem_we  = done && dph_q.wr;
  end

  // next state: finish/advance the current phase, a new accept overrides
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dph_d   = dph_q;
    case (state_q)
      S_DATA:  if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
               else               state_d = S_IDLE;
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      state_d   = err_hit ? S_ERR1 : S_DATA;
      // errors never wait; SEQ beats skip waits when SEQ_WAIT is off
      cnt_d     = (err_hit || (!SEQ_WAIT && bus.HTRANS == TR_SEQ)) ? 4'd0 : WaitCycles;
      dph_d.idx = bus.HADDR[BO +: IW];
      dph_d.wr  = bus.HWRITE;
    end
  end

  // control state; reset drops any transfer in flight
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      dph_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dph_q   <= dph_d;
    end
  end

  // byte-strobed write at the edge that ends the completion cycle
  always_ff @(posedge HCLK) begin
    if (mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (bus.HWSTRB[b]) mem_q[dph_q.idx][8*b +: 8] <= bus.HWDATA[8*b +: 8];
      end
    end
  end

  // responses decode purely from state, so reset forces them immediately
  always_comb begin
    bus.HREADYEXT = !(((state_q == S_DATA) && (cnt_q != 4'd0)) || (state_q == S_ERR1));
    bus.HRESPEXT  = state_q[1];
    bus.HRDATAEXT = (done && !dph_q.wr) ? mem_q[dph_q.idx] : '0;
  end
endmodule

// File: tb/tb_ahb_ext_responder.sv
// Bench for ahb_ext_responder: vector table issued through a pipelined driver,
// expected responses queued at accept and compared at completion.
module tb_ahb_ext_responder;
  localparam int AHBW = 64;
  localparam int PA   = 34;
  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NS = 2'b10, T_SEQ = 2'b11;

  typedef struct {
    logic [PA-1:0]   addr;
    bit              wr;
    logic [1:0]      trans;
    logic [AHBW-1:0] wdata;
    logic [7:0]      strb;
    logic [3:0]      waitc;
    logic [AHBW-1:0] exp_rdata;
    bit              exp_err;
    int              exp_wait;
    bit              drain;
  } vec_t;

  typedef struct {
    bit              wr;
    logic [AHBW-1:0] rdata;
    bit              err;
    int              waitn;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] wait_cycles;

  ahb_ext_responder_if #(.AHBW(AHBW), .PA_BITS(PA)) bus ();
  assign bus.HREADY = bus.HREADYEXT;

  ahb_ext_responder #(
    .AHBW(AHBW), .PA_BITS(PA), .DEPTH(256),
    .ERR_BASE(34'h2000), .ERR_MASK(34'hFFF), .ERR_EN(1'b1), .SEQ_WAIT(1'b0)
  ) dut (
    .HCLK(clk), .HRESETn(rst_n), .WaitCycles(wait_cycles), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t            exp_q[$];
  vec_t            tv[21];
  int              checks = 0;
  int              errors = 0;
  bit              dp_active = 1'b0;
  int              lowcnt = 0;
  bit              lowresp = 1'b0;
  logic [AHBW-1:0] dp_wdata = '0;
  logic [7:0]      dp_strb = '0;

  function automatic vec_t mk(logic [PA-1:0] a, bit w, logic [1:0] t, logic [AHBW-1:0] d,
                              logic [7:0] s, logic [3:0] wc, logic [AHBW-1:0] er,
                              bit ee, int ew, bit dr);
    vec_t v;
    v.addr = a; v.wr = w; v.trans = t; v.wdata = d; v.strb = s; v.waitc = wc;
    v.exp_rdata = er; v.exp_err = ee; v.exp_wait = ew; v.drain = dr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [AHBW-1:0] act, input logic [AHBW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // called at every falling edge: idle checks, wait counting, completion compare
  task automatic mon();
    exp_t e;
    if (!dp_active) begin
      chk("idle_hready", 64'(bus.HREADYEXT), 64'd1);
      chk("idle_hresp",  64'(bus.HRESPEXT),  64'd0);
      chk("idle_hrdata", bus.HRDATAEXT, 64'd0);
    end else if (!bus.HREADYEXT) begin
      lowcnt++;
      if (bus.HRESPEXT) lowresp = 1'b1;
      if (lowcnt > 20) begin
        checks++; errors++;
        $display("FAIL wait_timeout: HREADYEXT low %0d cycles, expected completion", lowcnt);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        dp_active = 1'b0; lowcnt = 0; lowresp = 1'b0;
      end
    end else begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_empty: completion seen, expected none pending");
      end else begin
        e = exp_q.pop_front();
        chk("resp",  64'(bus.HRESPEXT), 64'(e.err));
        chk("waits", 64'(lowcnt), 64'(e.waitn));
        if (e.err) chk("err_first_resp", 64'(lowresp), 64'd1);
        if (!e.wr) chk("rdata", bus.HRDATAEXT, e.rdata);
      end
      dp_active = 1'b0; lowcnt = 0; lowresp = 1'b0;
    end
  endtask

  task automatic idle_cycle(input bit sel, input logic [1:0] tr);
    @(negedge clk);
    mon();
    bus.HWDATA = dp_wdata; bus.HWSTRB = dp_strb;
    bus.HSELEXT = sel; bus.HTRANS = tr;
    wait_cycles = 4'($urandom_range(0, 15));
    @(posedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && dp_active; i++) idle_cycle(1'b0, T_IDLE);
  endtask

  // present an address phase, holding it until the bus is ready
  task automatic issue(input vec_t v);
    bit ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      mon();
      bus.HWDATA = dp_wdata; bus.HWSTRB = dp_strb;
      if (bus.HREADYEXT) begin
        bus.HSELEXT = 1'b1; bus.HADDR = v.addr; bus.HTRANS = v.trans;
        bus.HWRITE = v.wr; bus.HSIZE = 3'b011; wait_cycles = v.waitc;
        @(posedge clk);
        exp_q.push_back('{v.wr, v.exp_rdata, v.exp_err, v.exp_wait});
        dp_active = 1'b1; dp_wdata = v.wdata; dp_strb = v.strb; ok = 1'b1;
      end else begin
        // changing WaitCycles mid data phase must not affect the transfer
        wait_cycles = 4'($urandom_range(0, 15));
        @(posedge clk);
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL issue_timeout: addr %h not accepted, expected acceptance within 40 cycles", v.addr);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    //          addr        wr  trans   wdata                  strb   wc    exp_rdata              err  wait drain
    tv[0]  = mk(34'h100,  1, T_NS,  64'h1122334455667788, 8'hFF, 4'd0, 64'h0,                0, 0, 0);
    tv[1]  = mk(34'h100,  0, T_NS,  64'h0,                8'h00, 4'd0, 64'h1122334455667788, 0, 0, 0);
    tv[2]  = mk(34'h100,  1, T_NS,  64'hFFFFFFFFFFFFFFFF, 8'h0F, 4'd0, 64'h0,                0, 0, 0);
    tv[3]  = mk(34'h100,  0, T_NS,  64'h0,                8'h00, 4'd0, 64'h11223344FFFFFFFF, 0, 0, 0);
    tv[4]  = mk(34'h100,  0, T_NS,  64'h0,                8'h00, 4'd3, 64'h11223344FFFFFFFF, 0, 3, 1);
    tv[5]  = mk(34'h10,   1, T_NS,  64'hA5A500005A5A1234, 8'hFF, 4'd0, 64'h0,                0, 0, 0);
    tv[6]  = mk(34'h2010, 1, T_NS,  64'hDEADBEEFDEADBEEF, 8'hFF, 4'd4, 64'h0,                1, 1, 0);
    tv[7]  = mk(34'h2010, 0, T_NS,  64'h0,                8'h00, 4'd0, 64'h0,                1, 1, 0);
    tv[8]  = mk(34'h10,   0, T_NS,  64'h0,                8'h00, 4'd0, 64'hA5A500005A5A1234, 0, 0, 0);
    tv[9]  = mk(34'h810,  0, T_NS,  64'h0,                8'h00, 4'd2, 64'hA5A500005A5A1234, 0, 2, 0);
    tv[10] = mk(34'h300,  1, T_NS,  64'h1111111111111111, 8'hFF, 4'd1, 64'h0,                0, 1, 0);
    tv[11] = mk(34'h308,  1, T_SEQ, 64'h2222222222222222, 8'hFF, 4'd1, 64'h0,                0, 0, 0);
    tv[12] = mk(34'h310,  1, T_SEQ, 64'h3333333333333333, 8'hFF, 4'd1, 64'h0,                0, 0, 0);
    tv[13] = mk(34'h318,  1, T_SEQ, 64'h4444444444444444, 8'hFF, 4'd1, 64'h0,                0, 0, 0);
    tv[14] = mk(34'h300,  0, T_NS,  64'h0,                8'h00, 4'd3, 64'h1111111111111111, 0, 3, 0);
    tv[15] = mk(34'h308,  0, T_SEQ, 64'h0,                8'h00, 4'd3, 64'h2222222222222222, 0, 0, 0);
    tv[16] = mk(34'h310,  0, T_SEQ, 64'h0,                8'h00, 4'd3, 64'h3333333333333333, 0, 0, 0);
    tv[17] = mk(34'h318,  0, T_SEQ, 64'h0,                8'h00, 4'd3, 64'h4444444444444444, 0, 0, 0);
    tv[18] = mk(34'h308,  1, T_NS,  64'hCAFEBABE00000000, 8'hF0, 4'd2, 64'h0,                0, 2, 0);
    tv[19] = mk(34'h308,  0, T_NS,  64'h0,                8'h00, 4'd0, 64'hCAFEBABE22222222, 0, 0, 0);
    tv[20] = mk(34'h200,  1, T_NS,  64'h0123456789ABCDEF, 8'hFF, 4'd0, 64'h0,                0, 0, 1);

    bus.HSELEXT = 1'b0; bus.HADDR = '0; bus.HTRANS = T_IDLE; bus.HWRITE = 1'b0;
    bus.HSIZE = 3'b011; bus.HWDATA = '0; bus.HWSTRB = '0; wait_cycles = 4'd0;

    // reset, then idle / BUSY cycles must answer OKAY zero-wait
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) idle_cycle(1'b0, T_IDLE);
    idle_cycle(1'b1, T_BUSY);
    idle_cycle(1'b1, T_IDLE);
    idle_cycle(1'b0, T_IDLE);

    foreach (tv[i]) begin
      issue(tv[i]);
      if (tv[i].drain) drain();
    end
    drain();

    // reset during the wait states of a write: the write must be dropped
    @(negedge clk);
    mon();
    bus.HSELEXT = 1'b1; bus.HADDR = 34'h200; bus.HTRANS = T_NS; bus.HWRITE = 1'b1;
    wait_cycles = 4'd5;
    @(posedge clk);
    @(negedge clk);
    bus.HSELEXT = 1'b0; bus.HTRANS = T_IDLE;
    bus.HWDATA = 64'hFFFFFFFFFFFFFFFF; bus.HWSTRB = 8'hFF;
    chk("rst_wait1_hready", 64'(bus.HREADYEXT), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_wait2_hready", 64'(bus.HREADYEXT), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_async_hready", 64'(bus.HREADYEXT), 64'd1);
    chk("rst_async_hresp",  64'(bus.HRESPEXT),  64'd0);
    chk("rst_async_hrdata", bus.HRDATAEXT, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    dp_wdata = '0; dp_strb = '0;
    issue(mk(34'h200, 0, T_NS, 64'h0, 8'h00, 4'd0, 64'h0123456789ABCDEF, 0, 0, 1));
    drain();
    idle_cycle(1'b0, T_IDLE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
